vmu_operand_seq: RTL and testbench
==================================

# vmu_operand_seq

Operand sequencer in front of the six-source VMU operand mux. It accepts a command (source select, vector length in beats), drives the mux enable and select, and pulls one `VMU_OP_NUM`-lane beat per cycle from the selected source. Each beat is registered into a 2-entry skid buffer and delivered to the VMU over a valid/ready stream with a last flag. It pulses `done` when the final beat has been consumed.

## Interface
Parameters:
- `DATA_W`, default `` `VMU_DATA_WIDTH ``: width of one lane.
- `OP_NUM`, default `` `VMU_OP_NUM ``: lanes per beat.
- `LEN_W`, default 8: width of the beat-count field.

Ports:
- `clk`  in  1  the block's single clock.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when high together with `cmd_valid`.
- `cmd_sel`  in  3  source select, 0..5.
- `cmd_len`  in  `LEN_W`  number of beats.
- `data_mux_en`  out  1  enable to the operand mux.
- `data_sel`  out  3  select to the operand mux.
- `mux_data`  in  `DATA_W*OP_NUM`  mux output, combinational in the same cycle.
- `src_rd`  out  1  beat taken; the selected source advances to its next beat on this edge.
- `out_valid`  out  1  a beat is presented to the VMU.
- `out_ready`  in  1  VMU accepts the beat.
- `out_data`  out  `DATA_W*OP_NUM`  beat payload.
- `out_last`  out  1  marks the final beat of the command.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse, coincident with `done`, when the command's `cmd_sel` was greater than 5.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- **IDLE**
  - `cmd_ready` is high.
  - On `cmd_valid`, latch `cmd_sel` and `cmd_len`, and clear the beat counter.
  - If `cmd_len` is 0: stay in IDLE, and pulse `done` (and `err` if the select was invalid) on the next cycle. No beats and no `src_rd`.
  - Otherwise go to RUN.
- **RUN**
  - `data_mux_en` is 1 and `data_sel` is the latched select.
  - Capture condition: buffer occupancy < 2, or occupancy == 2 with a pop this cycle.
  - On capture, `mux_data` is written to the buffer, `src_rd` is 1, and the beat counter increments.
  - The entry is tagged last when counter == len-1. On that capture, go to DRAIN.
- **DRAIN**
  - `data_mux_en` is 0, `data_sel` holds its value, and `src_rd` is 0.
  - On the `out_valid & out_ready & out_last` handshake, go to IDLE. `done` (and `err`) pulse on the following cycle.
- **Skid buffer**
  - 2-entry FIFO; `out_*` always reflect the head entry.
  - Push and pop in the same cycle are legal at any occupancy.
  - Never pushes when full without a pop.
- **Invalid select (6 or 7)**
  - Runs normally; the mux outputs zeros, so all beats carry zero data.
  - `err` pulses with `done`.
- `cmd_ready` is 0 outside IDLE. A new command is never accepted in the same cycle as `done`. The earliest acceptance is the cycle after returning to IDLE.
- The beat counter is `LEN_W` bits. The maximum length is 2^`LEN_W`-1 beats, and the counter never wraps within a command.

## Timing
- Reset (synchronous `rst`):
  - State IDLE, buffer empty, counter 0.
  - All outputs 0 except `cmd_ready`, which is 1 (it is derived from the IDLE state).
  - A reset mid-command discards buffered beats with no `done` or `err`. The source pointer is the upstream block's own responsibility.
- Latency:
  - Command accepted in cycle T.
  - First `data_mux_en`/`src_rd` in T+1.
  - First `out_valid` in T+2.
- Throughput: 1 beat per cycle while `out_ready` is held high.
- Backpressure:
  - With `out_ready` low, RUN captures at most 2 beats, then `src_rd` stays low until the VMU pops.
  - `out_data` and `out_last` are stable while `out_valid` is high and `out_ready` is low.
- `done` pulses 1 cycle after the last output handshake. `busy` falls in that same cycle.

## Structure
- Shared package/define file:
  - FSM state encodings (IDLE=0, RUN=1, DRAIN=2).
  - Source count constant `VMU_SRC_NUM` = 6.
  - Select width = 3.
  - Reuses `VMU_DATA_WIDTH` and `VMU_OP_NUM` from the shared defines.
- Sub-module `vmu_skid_buf`:
  - 2-entry FIFO of width `DATA_W*OP_NUM+1` (payload plus last bit).
  - push/pop/full/empty interface, synchronous active-high reset.
- Top level: FSM, beat counter, and capture logic.

## Test plan
- Command sel=2, len=4, `out_ready` held 1 → `data_sel`=2 and `src_rd` high for 4 consecutive cycles starting T+1; 4 beats equal to source-2 values on consecutive cycles from T+2; `out_last` on the 4th beat; `done` the cycle after.
- Command sel=0, len=5, `out_ready` low for 6 cycles then high → exactly 2 `src_rd` pulses during the stall; data order is preserved; all 5 beats are delivered with no duplicates or drops.
- Command len=0 → no `src_rd`, no `out_valid`; `done` pulses the cycle after acceptance; `busy` never rises.
- Command sel=7, len=2 → 2 all-zero beats, then `done` and `err` pulse together.
- `rst` asserted in the middle of a len=8 command after 3 beats → next cycle all outputs are at reset values and `cmd_ready`=1; a new sel=1, len=1 command completes cleanly.
- Back-to-back commands with `cmd_valid` held → the second command is accepted only the cycle after returning to IDLE, and the `done` pulses are distinct.

Source files
------------

// File: rtl/vmu_operand_seq_pkg.sv
// Shared types and constants for the VMU operand sequencer.
// Lane width and lane count fall back to local values when no shared define is present.
`ifndef VMU_DATA_WIDTH
`define VMU_DATA_WIDTH 8
`endif
`ifndef VMU_OP_NUM
`define VMU_OP_NUM 4
`endif

package vmu_operand_seq_pkg;

    localparam int unsigned VMU_SRC_NUM = 6;
    localparam int unsigned SEL_W       = 3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } seq_state_e;

    // Selects past the last mux source are accepted but flagged on completion.
    function automatic logic sel_invalid(input logic [SEL_W-1:0] sel);
        return 32'(sel) >= VMU_SRC_NUM;
    endfunction

endpackage

// File: rtl/vmu_skid_buf.sv
// Two-entry FIFO between the operand mux capture and the VMU stream.
// Head entry is visible combinationally; push and pop may coincide at any occupancy.
module vmu_skid_buf #(
    parameter int unsigned Width = 33
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [Width-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign do_pop  = pop_i && !empty_o;
    // When full, a push only lands if the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/vmu_operand_seq.sv
// Operand sequencer: walks one command's beats out of the six-source operand mux
// and streams them to the VMU through a two-entry skid buffer.
`ifndef VMU_DATA_WIDTH
`define VMU_DATA_WIDTH 8
`endif
`ifndef VMU_OP_NUM
`define VMU_OP_NUM 4
`endif

module vmu_operand_seq
    import vmu_operand_seq_pkg::*;
#(
    parameter int unsigned DATA_W = `VMU_DATA_WIDTH,
    parameter int unsigned OP_NUM = `VMU_OP_NUM,
    parameter int unsigned LEN_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [SEL_W-1:0]         cmd_sel,
    input  logic [LEN_W-1:0]         cmd_len,
    output logic                     data_mux_en,
    output logic [SEL_W-1:0]         data_sel,
    input  logic [DATA_W*OP_NUM-1:0] mux_data,
    output logic                     src_rd,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W*OP_NUM-1:0] out_data,
    output logic                     out_last,
    output logic                     done,
    output logic                     err,
    output logic                     busy
);

    localparam int unsigned BeatW = DATA_W * OP_NUM;

    seq_state_e       state_q;
    logic [SEL_W-1:0] sel_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic             done_q;
    logic             err_q;

    logic             buf_full;
    logic             buf_empty;
    logic [BeatW:0]   buf_rdata;
    logic             pop;
    logic             capture;
    logic             cap_last;

    assign pop      = !buf_empty && out_ready;
    assign capture  = (state_q == StRun) && (!buf_full || pop);
    assign cap_last = (cnt_q == len_q - LEN_W'(1));

    vmu_skid_buf #(
        .Width (BeatW + 1)
    ) u_skid_buf (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (capture),
        .wdata_i ({cap_last, mux_data}),
        .pop_i   (pop),
        .rdata_o (buf_rdata),
        .full_o  (buf_full),
        .empty_o (buf_empty)
    );

    // The done cycle is kept out of acceptance so completions never overlap a new command.
    assign cmd_ready   = (state_q == StIdle) && !done_q;
    assign busy        = (state_q != StIdle);
    assign data_mux_en = (state_q == StRun);
    assign data_sel    = sel_q;
    assign src_rd      = capture;
    assign out_valid   = !buf_empty;
    assign out_data    = out_valid ? buf_rdata[BeatW-1:0] : '0;
    assign out_last    = out_valid && buf_rdata[BeatW];
    assign done        = done_q;
    assign err         = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sel_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (cmd_valid && cmd_ready) begin
                        sel_q <= cmd_sel;
                        len_q <= cmd_len;
                        cnt_q <= '0;
                        if (cmd_len == '0) begin
                            done_q <= 1'b1;
                            err_q  <= sel_invalid(cmd_sel);
                        end else begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (capture) begin
                        cnt_q <= cnt_q + LEN_W'(1);
                        if (cap_last) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (pop && out_last) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                        err_q   <= sel_invalid(sel_q);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_vmu_operand_seq.sv
// Directed bench for vmu_operand_seq with a modelled six-source mux and a beat scoreboard.
module tb_vmu_operand_seq;

  localparam int DATA_W = 8;
  localparam int OP_NUM = 4;
  localparam int LEN_W  = 8;
  localparam int BEAT_W = DATA_W * OP_NUM;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [2:0]        cmd_sel = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              data_mux_en;
  logic [2:0]        data_sel;
  logic [BEAT_W-1:0] mux_data;
  logic              src_rd;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [BEAT_W-1:0] out_data;
  logic              out_last;
  logic              done;
  logic              err;
  logic              busy;

  int vectors     = 0;
  int miscompares = 0;
  int rd_cnt      = 0;
  int hs_cnt      = 0;
  int src_ptr [8];
  logic [BEAT_W:0] exp_q [$];

  vmu_operand_seq #(
    .DATA_W (DATA_W),
    .OP_NUM (OP_NUM),
    .LEN_W  (LEN_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_sel     (cmd_sel),
    .cmd_len     (cmd_len),
    .data_mux_en (data_mux_en),
    .data_sel    (data_sel),
    .mux_data    (mux_data),
    .src_rd      (src_rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .done        (done),
    .err         (err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [BEAT_W-1:0] src_val(input int sel, input int idx);
    return {8'(sel + 1), 8'(idx), 8'h5A, 8'(sel * 37 + idx * 3)};
  endfunction

  task automatic fail(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    miscompares++;
    $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Source model: six sources, each advancing on src_rd; selects 6/7 read as zero.
  assign mux_data = (data_mux_en && data_sel < 3'd6) ?
                    src_val(int'(data_sel), src_ptr[data_sel]) : '0;

  always @(posedge clk) begin
    if (src_rd && data_sel < 3'd6) begin
      src_ptr[data_sel] <= src_ptr[data_sel] + 1;
    end
  end

  always @(negedge clk) begin
    if (src_rd) begin
      rd_cnt++;
    end
    if (out_valid && out_ready && !rst) begin
      hs_cnt++;
      vectors++;
      if (exp_q.size() == 0) fail("beat_expected", exp_q.size(), 1);
      if (exp_q.size() != 0) begin
        logic [BEAT_W:0] e;
        e = exp_q.pop_front();
        vectors++;
        if (out_data !== e[BEAT_W-1:0]) fail("beat_data", out_data, e[BEAT_W-1:0]);
        vectors++;
        if (out_last !== e[BEAT_W]) fail("beat_last", out_last, e[BEAT_W]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cmd(input int sel, input int len, input int off);
    for (int i = 0; i < len; i++) begin
      logic [BEAT_W-1:0] d;
      d = (sel < 6) ? src_val(sel, src_ptr[sel] + off + i) : '0;
      exp_q.push_back({(i == len - 1) ? 1'b1 : 1'b0, d});
    end
  endtask

  task automatic send_cmd(input int sel, input int len);
    expect_cmd(sel, len, 0);
    cmd_valid = 1'b1;
    cmd_sel   = 3'(sel);
    cmd_len   = LEN_W'(len);
    vectors++;
    if (cmd_ready !== 1'b1) fail("cmd_ready_T", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      if (done) seen = 1'b1;
      else tick();
    end
  endtask

  task automatic chk_idle_outputs();
    vectors++;
    if (cmd_ready !== 1'b1) fail("idle_cmd_ready", cmd_ready, 1'b1);
    vectors++;
    if (busy !== 1'b0) fail("idle_busy", busy, 1'b0);
    vectors++;
    if (data_mux_en !== 1'b0) fail("idle_mux_en", data_mux_en, 1'b0);
    vectors++;
    if (data_sel !== 3'd0) fail("idle_data_sel", data_sel, 3'd0);
    vectors++;
    if (src_rd !== 1'b0) fail("idle_src_rd", src_rd, 1'b0);
    vectors++;
    if (out_valid !== 1'b0) fail("idle_out_valid", out_valid, 1'b0);
    vectors++;
    if (out_data !== {BEAT_W{1'b0}}) fail("idle_out_data", out_data, 0);
    vectors++;
    if (out_last !== 1'b0) fail("idle_out_last", out_last, 1'b0);
    vectors++;
    if (done !== 1'b0) fail("idle_done", done, 1'b0);
    vectors++;
    if (err !== 1'b0) fail("idle_err", err, 1'b0);
  endtask

  initial begin
    bit seen;
    int base_rd;
    int base_hs;
    int n_acc;
    int n_dn;
    int acc [4];
    int dn [4];

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk_idle_outputs();
    rst = 1'b0;
    tick();

    // sel=2 len=4, full throughput
    out_ready = 1'b1;
    send_cmd(2, 4);
    vectors++;
    if (data_mux_en !== 1'b1) fail("t1_mux_en", data_mux_en, 1'b1);
    vectors++;
    if (data_sel !== 3'd2) fail("t1_data_sel", data_sel, 3'd2);
    vectors++;
    if (src_rd !== 1'b1) fail("t1_src_rd_first", src_rd, 1'b1);
    vectors++;
    if (out_valid !== 1'b0) fail("t1_no_valid_T1", out_valid, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (out_valid !== 1'b1) fail("t1_out_valid", out_valid, 1'b1);
      vectors++;
      if (src_rd !== ((i < 3) ? 1'b1 : 1'b0)) fail("t1_src_rd", src_rd, (i < 3));
      vectors++;
      if (out_last !== ((i == 3) ? 1'b1 : 1'b0)) fail("t1_out_last", out_last, (i == 3));
      tick();
    end
    vectors++;
    if (done !== 1'b1) fail("t1_done", done, 1'b1);
    vectors++;
    if (err !== 1'b0) fail("t1_err", err, 1'b0);
    vectors++;
    if (busy !== 1'b0) fail("t1_busy_fall", busy, 1'b0);
    vectors++;
    if (cmd_ready !== 1'b0) fail("t1_ready_done_cycle", cmd_ready, 1'b0);
    tick();
    vectors++;
    if (done !== 1'b0) fail("t1_done_one_cycle", done, 1'b0);
    vectors++;
    if (cmd_ready !== 1'b1) fail("t1_ready_after", cmd_ready, 1'b1);
    vectors++;
    if (exp_q.size() != 0) fail("t1_queue_empty", exp_q.size(), 0);

    // sel=0 len=5 with six cycles of backpressure
    out_ready = 1'b0;
    base_rd = rd_cnt;
    base_hs = hs_cnt;
    send_cmd(0, 5);
    tick();
    tick();
    for (int j = 0; j < 3; j++) begin
      vectors++;
      if (out_valid !== 1'b1) fail("t2_stall_valid", out_valid, 1'b1);
      vectors++;
      if (out_data !== exp_q[0][BEAT_W-1:0]) fail("t2_stall_data", out_data, exp_q[0][BEAT_W-1:0]);
      vectors++;
      if (src_rd !== 1'b0) fail("t2_stall_src_rd", src_rd, 1'b0);
      tick();
    end
    vectors++;
    if (rd_cnt - base_rd != 2) fail("t2_src_rd_during_stall", rd_cnt - base_rd, 2);
    out_ready = 1'b1;
    wait_done(40, seen);
    vectors++;
    if (seen !== 1'b1) fail("t2_done_seen", seen, 1'b1);
    vectors++;
    if (hs_cnt - base_hs != 5) fail("t2_beats_delivered", hs_cnt - base_hs, 5);
    vectors++;
    if (exp_q.size() != 0) fail("t2_queue_empty", exp_q.size(), 0);
    tick();

    // len=0: immediate done, no beats
    base_rd = rd_cnt;
    send_cmd(3, 0);
    vectors++;
    if (done !== 1'b1) fail("t3_done", done, 1'b1);
    vectors++;
    if (err !== 1'b0) fail("t3_err", err, 1'b0);
    vectors++;
    if (busy !== 1'b0) fail("t3_busy", busy, 1'b0);
    vectors++;
    if (out_valid !== 1'b0) fail("t3_out_valid", out_valid, 1'b0);
    vectors++;
    if (cmd_ready !== 1'b0) fail("t3_ready_done_cycle", cmd_ready, 1'b0);
    tick();
    vectors++;
    if (done !== 1'b0) fail("t3_done_cleared", done, 1'b0);
    vectors++;
    if (busy !== 1'b0) fail("t3_busy_after", busy, 1'b0);
    vectors++;
    if (rd_cnt - base_rd != 0) fail("t3_no_src_rd", rd_cnt - base_rd, 0);

    // Invalid select 7: zero beats, err with done
    send_cmd(7, 2);
    wait_done(20, seen);
    vectors++;
    if (seen !== 1'b1) fail("t4_done_seen", seen, 1'b1);
    vectors++;
    if (err !== 1'b1) fail("t4_err", err, 1'b1);
    vectors++;
    if (exp_q.size() != 0) fail("t4_queue_empty", exp_q.size(), 0);
    tick();
    vectors++;
    if (err !== 1'b0) fail("t4_err_cleared", err, 1'b0);

    // Reset in the middle of a len=8 command
    base_hs = hs_cnt;
    send_cmd(4, 8);
    for (int k = 0; k < 20 && (hs_cnt - base_hs) < 3; k++) tick();
    vectors++;
    if (hs_cnt - base_hs != 3) fail("t5_three_beats", hs_cnt - base_hs, 3);
    rst = 1'b1;
    tick();
    chk_idle_outputs();
    rst = 1'b0;
    exp_q.delete();
    tick();
    chk_idle_outputs();
    send_cmd(1, 1);
    wait_done(20, seen);
    vectors++;
    if (seen !== 1'b1) fail("t5_done_seen", seen, 1'b1);
    vectors++;
    if (err !== 1'b0) fail("t5_err", err, 1'b0);
    vectors++;
    if (exp_q.size() != 0) fail("t5_queue_empty", exp_q.size(), 0);
    tick();
    tick();

    // Back-to-back commands with cmd_valid held
    expect_cmd(5, 2, 0);
    expect_cmd(5, 2, 2);
    cmd_valid = 1'b1;
    cmd_sel   = 3'd5;
    cmd_len   = LEN_W'(2);
    n_acc = 0;
    n_dn  = 0;
    for (int k = 0; k < 24; k++) begin
      if (cmd_valid && cmd_ready && n_acc < 4) begin
        acc[n_acc] = k;
        n_acc++;
      end
      if (done && n_dn < 4) begin
        dn[n_dn] = k;
        n_dn++;
      end
      tick();
      if (n_acc == 2) cmd_valid = 1'b0;
    end
    vectors++;
    if (n_acc != 2) fail("t6_accepts", n_acc, 2);
    vectors++;
    if (n_dn != 2) fail("t6_dones", n_dn, 2);
    vectors++;
    if (acc[0] != 0) fail("t6_first_accept", acc[0], 0);
    vectors++;
    if (dn[0] != acc[0] + 4) fail("t6_done1_cycle", dn[0], acc[0] + 4);
    vectors++;
    if (acc[1] != dn[0] + 1) fail("t6_accept2_after_done1", acc[1], dn[0] + 1);
    vectors++;
    if (dn[1] != acc[1] + 4) fail("t6_done2_cycle", dn[1], acc[1] + 4);
    vectors++;
    if (exp_q.size() != 0) fail("t6_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
